// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle RV32I core
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       Illegal
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Counter is wide enough to reach the timeout and still saturate above it.
    localparam int CW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BEQ, JALR, JAL, LUI, TRAP
    } state_t;

    // fetch: IRWrite/PCUpdate qualified by MemReady; jump: unconditional PCUpdate
    typedef struct packed {
        logic       fetch;
        logic       jump;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.fetch = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECR:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
            LUI:      begin c.src_b = 2'b01; c.alu_op = 2'b11; end
            ALUWB:    c.reg_write = 1'b1;
            BEQ:      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            JALR:     begin c.src_a = 2'b10; c.src_b = 2'b01; end
            JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.jump = 1'b1; end
            TRAP:     c.illegal = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    state_t         state_q, state_d, dec_next;
    logic [CW-1:0]  cnt_q, cnt_d;
    ctrl_t          ctrl_q, ctrl_d;
    logic [2:0]     imm_src;
    logic           waiting;

    // Opcode dispatch out of DECODE; anything unrecognised traps.
    always_comb begin
        dec_next = op == OP_LW || op == OP_SW ? MEMADR :
                   op == OP_R    ? EXECR :
                   op == OP_I    ? EXECI :
                   op == OP_BEQ  ? BEQ   :
                   op == OP_JAL  ? JAL   :
                   op == OP_JALR ? JALR  :
                   op == OP_LUI  ? LUI   : TRAP;
    end

    // Next state, memory-wait counter and the control word for the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        waiting = state_q inside {FETCH, MEMREAD, MEMWRITE};
        case (state_q)
            FETCH:    state_d = MemReady ? DECODE : FETCH;
            DECODE:   state_d = dec_next;
            MEMADR:   state_d = op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ: state_d = FETCH;
            EXECR, EXECI, LUI, JAL: state_d = ALUWB;
            JALR:     state_d = JAL;
            default:  state_d = TRAP;
        endcase
        if (waiting && !MemReady) begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            if (MEM_TIMEOUT > 0 && cnt_q == LIMIT) state_d = TRAP;
        end
        ctrl_d = ctrl_of(state_d);
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src = op == OP_SW  ? 3'b001 :
                  op == OP_BEQ ? 3'b010 :
                  op == OP_LUI ? 3'b011 :
                  op == OP_JAL ? 3'b100 : 3'b000;
    end

    // State, counter and registered control word; reset lands in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            ctrl_q  <= ctrl_of(FETCH);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Everything is forced low while reset is held so no enable can leak out.
    assign PCWrite   = !reset && ((ctrl_q.fetch && MemReady) || ctrl_q.jump || (ctrl_q.branch && zero));
    assign IRWrite   = !reset && ctrl_q.fetch && MemReady;
    assign AdrSrc    = !reset && ctrl_q.adr_src;
    assign MemWrite  = !reset && ctrl_q.mem_write;
    assign RegWrite  = !reset && ctrl_q.reg_write;
    assign Illegal   = !reset && ctrl_q.illegal;
    assign ResultSrc = reset ? 2'b00 : ctrl_q.result_src;
    assign ALUSrcA   = reset ? 2'b00 : ctrl_q.src_a;
    assign ALUSrcB   = reset ? 2'b00 : ctrl_q.src_b;
    assign ALUOp     = reset ? 2'b00 : ctrl_q.alu_op;
    assign ImmSrc    = reset ? 3'b000 : imm_src;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multi-cycle control FSM
module tb_multicycle_controller;
    logic       clk, reset, zero, MemReady;
    logic [6:0] op;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_RegWrite, t_Illegal;
    logic [1:0] t_ResultSrc, t_ALUSrcA, t_ALUSrcB, t_ALUOp;
    logic [2:0] t_ImmSrc;
    logic [16:0] outs, outs_to;
    int passed = 0;
    int total = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal)
    );

    multicycle_controller #(.MEM_TIMEOUT(4)) u_to (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .MemReady(MemReady),
        .PCWrite(t_PCWrite), .AdrSrc(t_AdrSrc), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite),
        .RegWrite(t_RegWrite), .ResultSrc(t_ResultSrc), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB),
        .ALUOp(t_ALUOp), .ImmSrc(t_ImmSrc), .Illegal(t_Illegal)
    );

    assign outs    = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal};
    assign outs_to = {t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_RegWrite, t_ResultSrc, t_ALUSrcA, t_ALUSrcB, t_ALUOp, t_ImmSrc, t_Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] v(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] res, a, b, aop,
                                      input logic [2:0] imm, input logic ill);
        return {pcw, adr, mw, irw, rw, res, a, b, aop, imm, ill};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%b exp=%b", tag, got, exp);
    endtask

    initial begin
        reset = 1'b1; op = 7'b0110011; zero = 1'b0; MemReady = 1'b1;
        repeat (3) begin
            tick;
            chk("reset_low", outs, 17'd0);
        end
        reset = 1'b0; #1;
        chk("r_fetch",  outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        tick; chk("r_decode", outs, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        tick; chk("r_exec",   outs, v(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0));
        tick; chk("r_aluwb",  outs, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        tick; op = 7'b0000011; #1;
        chk("lw_fetch",  outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        tick; tick; chk("lw_memadr", outs, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        MemReady = 1'b0;
        tick; chk("lw_memread4", outs, v(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        tick; chk("lw_memread5", outs, v(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        tick; MemReady = 1'b1; #1;
        chk("lw_memread6", outs, v(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        tick; chk("lw_memwb7", outs, v(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
        tick; chk("lw_refetch", outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        op = 7'b0100011; #1;
        chk("sw_fetch",  outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b001,0));
        tick; chk("sw_decode", outs, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b001,0));
        tick; MemReady = 1'b0;
        tick; chk("sw_memwrite", outs, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0));
        tick; chk("sw_hold", outs, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0));
        MemReady = 1'b1; #1;
        chk("sw_ready", outs, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0));
        tick; chk("sw_refetch", outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b001,0));
        op = 7'b1100011; #1;
        chk("beq_fetch", outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0));
        tick; zero = 1'b1; #1;
        chk("beq_decode_zero_ignored", outs, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
        tick; chk("beq_taken", outs, v(1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0));
        zero = 1'b0; #1;
        chk("beq_not_taken", outs, v(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0));
        tick; chk("beq_refetch", outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0));
        op = 7'b1100111;
        tick; tick; chk("jalr_jalr", outs, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        tick; chk("jalr_jal",  outs, v(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0));
        tick; chk("jalr_aluwb", outs, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        tick; op = 7'b1101111;
        tick; tick; chk("jal_jal", outs, v(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b100,0));
        tick; chk("jal_aluwb", outs, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b100,0));
        tick; op = 7'b0110111;
        tick; tick; chk("lui_lui", outs, v(0,0,0,0,0,2'b00,2'b00,2'b01,2'b11,3'b011,0));
        tick; chk("lui_aluwb", outs, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b011,0));
        tick; op = 7'b0010011;
        tick; tick; chk("opimm_exec", outs, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0));
        tick; chk("opimm_aluwb", outs, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        tick; op = 7'b0100011;
        tick; tick; MemReady = 1'b0;
        tick; chk("mid_memwrite", outs, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0));
        reset = 1'b1; #1;
        chk("mid_reset", outs, 17'd0);
        tick; chk("mid_reset_hold", outs, 17'd0);
        reset = 1'b0; #1;
        chk("mid_fetch_stall", outs, v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0));
        MemReady = 1'b1; op = 7'b1111111; #1;
        chk("ill_fetch", outs, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        tick; chk("ill_decode", outs, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        tick; chk("ill_trap", outs, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
        for (int i = 0; i < 10; i++) begin
            MemReady = i[0]; zero = i[1];
            tick; chk("ill_stay", outs, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
        end
        op = 7'b0110011; MemReady = 1'b0; zero = 1'b0; reset = 1'b1;
        tick; reset = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait", outs_to, v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
            tick;
        end
        chk("to_trap", outs_to, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
        chk("no_to_wait", outs, v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        MemReady = 1'b1;
        tick; chk("to_trap_stay", outs_to, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
        chk("no_to_decode", outs, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
